// File: rtl/spec_regfile_pkg.sv
// Shared types and entry layout for the speculative register file.
// Packed entry order, MSB first: {rd_reg, pc, type, spec_data, spec_valid, valid}.
package spec_regfile_pkg;

    typedef enum logic [1:0] {
        ALU    = 2'd0,
        LOAD   = 2'd1,
        STORE  = 2'd2,
        BRANCH = 2'd3
    } inst_type_e;

    localparam int TYPE_W     = 2;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_PC_W   = 32;
    localparam int DEF_REG_AW = 5;

    localparam int OFF_VALID      = 0;
    localparam int OFF_SPEC_VALID = 1;
    localparam int OFF_DATA       = 2;

    function automatic int entry_w(input int reg_aw, input int pc_w,
                                   input int data_w);
        return reg_aw + pc_w + TYPE_W + data_w + 2;
    endfunction

    function automatic int off_type(input int data_w);
        return OFF_DATA + data_w;
    endfunction

    function automatic int off_pc(input int data_w);
        return OFF_DATA + data_w + TYPE_W;
    endfunction

    function automatic int off_rd_reg(input int data_w, input int pc_w);
        return OFF_DATA + data_w + TYPE_W + pc_w;
    endfunction

    typedef struct packed {
        logic [DEF_REG_AW-1:0] rd_reg;
        logic [DEF_PC_W-1:0]   pc;
        inst_type_e            itype;
        logic [DEF_DATA_W-1:0] spec_data;
        logic                  spec_valid;
        logic                  valid;
    } spec_entry_t;

endpackage

// File: rtl/spec_ring_ptr.sv
// Wrapping ring-buffer pointer; wraps naturally because DEPTH is a power of two.
module spec_ring_ptr #(
    parameter int IDX_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [IDX_W-1:0] ptr
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clear) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/spec_regfile_q.sv
// Speculative register file: in-order allocate/retire ring with out-of-order
// result fill and same-cycle update bypass on the read ports.
module spec_regfile_q
    import spec_regfile_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int DATA_W   = 32,
    parameter int PC_W     = 32,
    parameter int REG_AW   = 5,
    parameter int RD_PORTS = 2,
    localparam int IDX_W   = $clog2(DEPTH),
    localparam int ENTRY_W = entry_w(REG_AW, PC_W, DATA_W)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        alloc_valid,
    output logic                        alloc_ready,
    input  logic [REG_AW-1:0]           alloc_rd_reg,
    input  logic [PC_W-1:0]             alloc_pc,
    input  logic [1:0]                  alloc_type,
    output logic [IDX_W-1:0]            alloc_idx,
    input  logic                        upd_valid,
    input  logic [IDX_W-1:0]            upd_idx,
    input  logic [DATA_W-1:0]           upd_data,
    input  logic [RD_PORTS*IDX_W-1:0]   rd_addr,
    output logic [RD_PORTS*ENTRY_W-1:0] rd_entry,
    output logic                        retire_valid,
    input  logic                        retire_ready,
    output logic [IDX_W-1:0]            retire_idx,
    output logic [REG_AW-1:0]           retire_rd_reg,
    output logic [PC_W-1:0]             retire_pc,
    output logic [DATA_W-1:0]           retire_data,
    output logic [IDX_W:0]              count,
    output logic                        full,
    output logic                        empty
);

    localparam int CNT_W = IDX_W + 1;

    logic [REG_AW-1:0] rd_reg_q [DEPTH];
    logic [REG_AW-1:0] rd_reg_d [DEPTH];
    logic [PC_W-1:0]   pc_q     [DEPTH];
    logic [PC_W-1:0]   pc_d     [DEPTH];
    inst_type_e        type_q   [DEPTH];
    inst_type_e        type_d   [DEPTH];
    logic [DATA_W-1:0] data_q   [DEPTH];
    logic [DATA_W-1:0] data_d   [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;
    logic [DEPTH-1:0]  spec_valid_q;
    logic [DEPTH-1:0]  spec_valid_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic             alloc_fire;
    logic             upd_fire;
    logic             retire_fire;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    assign alloc_ready = !full;
    assign alloc_idx   = tail;

    assign retire_valid  = valid_q[head] && spec_valid_q[head];
    assign retire_idx    = head;
    assign retire_rd_reg = rd_reg_q[head];
    assign retire_pc     = pc_q[head];
    assign retire_data   = data_q[head];

    // Flush squashes every handshake in its cycle.
    assign alloc_fire  = !flush && alloc_valid && alloc_ready;
    assign upd_fire    = !flush && upd_valid && valid_q[upd_idx]
                         && !spec_valid_q[upd_idx];
    assign retire_fire = !flush && retire_valid && retire_ready;

    spec_ring_ptr #(.IDX_W(IDX_W)) u_head (
        .clock (clock),
        .reset (reset),
        .clear (flush),
        .inc   (retire_fire),
        .ptr   (head)
    );

    spec_ring_ptr #(.IDX_W(IDX_W)) u_tail (
        .clock (clock),
        .reset (reset),
        .clear (flush),
        .inc   (alloc_fire),
        .ptr   (tail)
    );

    always_comb begin
        rd_reg_d     = rd_reg_q;
        pc_d         = pc_q;
        type_d       = type_q;
        data_d       = data_q;
        valid_d      = valid_q;
        spec_valid_d = spec_valid_q;
        if (flush) begin
            valid_d      = '0;
            spec_valid_d = '0;
        end else begin
            if (upd_fire) begin
                data_d[upd_idx]       = upd_data;
                spec_valid_d[upd_idx] = 1'b1;
            end
            if (retire_fire) begin
                valid_d[head]      = 1'b0;
                spec_valid_d[head] = 1'b0;
            end
            if (alloc_fire) begin
                rd_reg_d[tail]     = alloc_rd_reg;
                pc_d[tail]         = alloc_pc;
                type_d[tail]       = inst_type_e'(alloc_type);
                data_d[tail]       = '0;
                valid_d[tail]      = 1'b1;
                spec_valid_d[tail] = 1'b0;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            unique case ({alloc_fire, retire_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_reg_q[i] <= '0;
                pc_q[i]     <= '0;
                type_q[i]   <= ALU;
                data_q[i]   <= '0;
            end
            valid_q      <= '0;
            spec_valid_q <= '0;
            count_q      <= '0;
        end else begin
            rd_reg_q     <= rd_reg_d;
            pc_q         <= pc_d;
            type_q       <= type_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            spec_valid_q <= spec_valid_d;
            count_q      <= count_d;
        end
    end

    // A read that hits the entry being filled this cycle sees the new result.
    for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
        logic [IDX_W-1:0] ridx;
        logic             hit;
        assign ridx = rd_addr[k*IDX_W +: IDX_W];
        assign hit  = upd_fire && (upd_idx == ridx);
        assign rd_entry[k*ENTRY_W +: ENTRY_W] = {
            rd_reg_q[ridx],
            pc_q[ridx],
            type_q[ridx],
            hit ? upd_data : data_q[ridx],
            hit | spec_valid_q[ridx],
            valid_q[ridx]
        };
    end

endmodule

// File: tb/tb_spec_regfile_q.sv
// Self-checking bench: directed corner cases plus random traffic
// against a behavioural ring-buffer model.
module tb_spec_regfile_q;
    import spec_regfile_pkg::*;

    localparam int DEPTH    = 32;
    localparam int DATA_W   = 32;
    localparam int PC_W     = 32;
    localparam int REG_AW   = 5;
    localparam int RD_PORTS = 2;
    localparam int IDX_W    = 5;
    localparam int ENTRY_W  = 73;

    logic                        clock;
    logic                        reset;
    logic                        flush;
    logic                        alloc_valid;
    logic                        alloc_ready;
    logic [REG_AW-1:0]           alloc_rd_reg;
    logic [PC_W-1:0]             alloc_pc;
    logic [1:0]                  alloc_type;
    logic [IDX_W-1:0]            alloc_idx;
    logic                        upd_valid;
    logic [IDX_W-1:0]            upd_idx;
    logic [DATA_W-1:0]           upd_data;
    logic [RD_PORTS*IDX_W-1:0]   rd_addr;
    logic [RD_PORTS*ENTRY_W-1:0] rd_entry;
    logic                        retire_valid;
    logic                        retire_ready;
    logic [IDX_W-1:0]            retire_idx;
    logic [REG_AW-1:0]           retire_rd_reg;
    logic [PC_W-1:0]             retire_pc;
    logic [DATA_W-1:0]           retire_data;
    logic [IDX_W:0]              count;
    logic                        full;
    logic                        empty;

    spec_regfile_q #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .PC_W(PC_W),
        .REG_AW(REG_AW), .RD_PORTS(RD_PORTS)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_rd_reg(alloc_rd_reg), .alloc_pc(alloc_pc),
        .alloc_type(alloc_type), .alloc_idx(alloc_idx),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_data(upd_data),
        .rd_addr(rd_addr), .rd_entry(rd_entry),
        .retire_valid(retire_valid), .retire_ready(retire_ready),
        .retire_idx(retire_idx), .retire_rd_reg(retire_rd_reg),
        .retire_pc(retire_pc), .retire_data(retire_data),
        .count(count), .full(full), .empty(empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk;
    int n_fail;

    bit          m_v    [DEPTH];
    bit          m_sv   [DEPTH];
    logic [31:0] m_data [DEPTH];
    logic [4:0]  m_reg  [DEPTH];
    logic [31:0] m_pc   [DEPTH];
    logic [1:0]  m_type [DEPTH];
    int          m_head;
    int          m_count;

    function automatic int m_tail();
        return (m_head + m_count) % DEPTH;
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic spec_entry_t port_entry(input int k);
        logic [ENTRY_W-1:0] raw;
        raw = rd_entry[k*ENTRY_W +: ENTRY_W];
        return spec_entry_t'(raw);
    endfunction

    function automatic logic [ENTRY_W-1:0] exp_entry(input int idx);
        spec_entry_t e;
        e.rd_reg     = m_reg[idx];
        e.pc         = m_pc[idx];
        e.itype      = inst_type_e'(m_type[idx]);
        e.spec_data  = m_data[idx];
        e.spec_valid = m_sv[idx];
        e.valid      = m_v[idx];
        if (!flush && upd_valid && int'(upd_idx) == idx
            && m_v[idx] && !m_sv[idx]) begin
            e.spec_data  = upd_data;
            e.spec_valid = 1'b1;
        end
        return e;
    endfunction

    task automatic check_all();
        chk("alloc_ready", alloc_ready, m_count < DEPTH);
        chk("alloc_idx", alloc_idx, m_tail());
        chk("count", count, m_count);
        chk("full", full, m_count == DEPTH);
        chk("empty", empty, m_count == 0);
        chk("retire_valid", retire_valid, m_v[m_head] && m_sv[m_head]);
        chk("retire_idx", retire_idx, m_head);
        chk("retire_rd_reg", retire_rd_reg, m_reg[m_head]);
        chk("retire_pc", retire_pc, m_pc[m_head]);
        chk("retire_data", retire_data, m_data[m_head]);
        for (int k = 0; k < RD_PORTS; k++) begin
            chk($sformatf("rd_entry[%0d]", k),
                rd_entry[k*ENTRY_W +: ENTRY_W],
                exp_entry(int'(rd_addr[k*IDX_W +: IDX_W])));
        end
    endtask

    task automatic model_step();
        int  t;
        int  u;
        bit  a;
        bit  r;
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_v[i] = 0; m_sv[i] = 0; m_data[i] = '0;
                m_reg[i] = '0; m_pc[i] = '0; m_type[i] = '0;
            end
            m_head = 0; m_count = 0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_v[i] = 0; m_sv[i] = 0;
            end
            m_head = 0; m_count = 0;
        end else begin
            t = m_tail();
            u = int'(upd_idx);
            a = alloc_valid && (m_count < DEPTH);
            r = m_v[m_head] && m_sv[m_head] && retire_ready;
            if (upd_valid && m_v[u] && !m_sv[u]) begin
                m_data[u] = upd_data;
                m_sv[u]   = 1;
            end
            if (r) begin
                m_v[m_head]  = 0;
                m_sv[m_head] = 0;
                m_head = (m_head + 1) % DEPTH;
            end
            if (a) begin
                m_v[t] = 1; m_sv[t] = 0; m_data[t] = '0;
                m_reg[t] = alloc_rd_reg; m_pc[t] = alloc_pc;
                m_type[t] = alloc_type;
            end
            m_count = m_count + int'(a) - int'(r);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic drive_check();
        #1;
        check_all();
    endtask

    task automatic idle();
        reset        = 1'b0;
        flush        = 1'b0;
        alloc_valid  = 1'b0;
        alloc_rd_reg = '0;
        alloc_pc     = '0;
        alloc_type   = '0;
        upd_valid    = 1'b0;
        upd_idx      = '0;
        upd_data     = '0;
        retire_ready = 1'b0;
    endtask

    typedef struct {
        logic        upd;
        logic [4:0]  uidx;
        logic [31:0] udata;
        logic        rready;
        logic        exp_rv;
        logic [4:0]  exp_ridx;
        logic [31:0] exp_rdata;
        logic [5:0]  exp_count;
    } vec_t;

    vec_t        vt [5];
    spec_entry_t e;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        vt[0] = '{1'b1, 5'd5, 32'hA5, 1'b1, 1'b0, 5'd0, 32'h0,  6'd32};
        vt[1] = '{1'b1, 5'd0, 32'h11, 1'b1, 1'b0, 5'd0, 32'h0,  6'd32};
        vt[2] = '{1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd0, 32'h11, 6'd32};
        vt[3] = '{1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 5'd0, 32'h11, 6'd31};
        vt[4] = '{1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 5'd1, 32'h0,  6'd31};

        idle();
        reset   = 1'b1;
        rd_addr = {5'd3, 5'd7};
        tick();
        tick();
        idle();
        drive_check();
        chk("rst alloc_ready", alloc_ready, 1);
        chk("rst alloc_idx", alloc_idx, 0);
        chk("rst retire_valid", retire_valid, 0);
        chk("rst retire_idx", retire_idx, 0);
        chk("rst retire_data", retire_data, 0);
        chk("rst count", count, 0);
        chk("rst empty", empty, 1);
        chk("rst full", full, 0);
        chk("rst rd_entry", rd_entry, 0);

        for (int i = 0; i < DEPTH; i++) begin
            alloc_valid  = 1'b1;
            alloc_rd_reg = 5'(i);
            alloc_pc     = 32'(4 * i);
            alloc_type   = 2'(i % 4);
            drive_check();
            chk("fill alloc_idx", alloc_idx, i);
            tick();
        end
        idle();
        drive_check();
        chk("fill full", full, 1);
        chk("fill alloc_ready", alloc_ready, 0);
        chk("fill count", count, 32);

        for (int i = 0; i < 5; i++) begin
            upd_valid    = vt[i].upd;
            upd_idx      = vt[i].uidx;
            upd_data     = vt[i].udata;
            retire_ready = vt[i].rready;
            drive_check();
            chk($sformatf("vec%0d retire_valid", i), retire_valid, vt[i].exp_rv);
            chk($sformatf("vec%0d retire_idx", i), retire_idx, vt[i].exp_ridx);
            chk($sformatf("vec%0d retire_rd_reg", i), retire_rd_reg, vt[i].exp_ridx);
            chk($sformatf("vec%0d retire_data", i), retire_data, vt[i].exp_rdata);
            tick();
            chk($sformatf("vec%0d count", i), count, vt[i].exp_count);
        end
        idle();

        rd_addr   = {5'd3, 5'd7};
        upd_valid = 1'b1;
        upd_idx   = 5'd3;
        upd_data  = 32'hDEAD;
        drive_check();
        e = port_entry(1);
        chk("bypass data", e.spec_data, 32'hDEAD);
        chk("bypass spec_valid", e.spec_valid, 1);
        tick();

        idle();
        upd_valid = 1'b1;
        upd_idx   = 5'd1;
        upd_data  = 32'h22;
        drive_check();
        tick();
        idle();
        alloc_valid  = 1'b1;
        alloc_rd_reg = 5'd9;
        alloc_pc     = 32'h100;
        drive_check();
        tick();
        retire_ready = 1'b1;
        drive_check();
        chk("full+retire alloc_ready", alloc_ready, 0);
        chk("full+retire retire_valid", retire_valid, 1);
        tick();
        idle();
        drive_check();
        chk("full+retire count", count, 31);
        chk("full+retire tail", alloc_idx, 1);

        rd_addr      = {5'd2, 5'd0};
        alloc_valid  = 1'b1;
        upd_valid    = 1'b1;
        upd_idx      = 5'd2;
        upd_data     = 32'h33;
        retire_ready = 1'b1;
        flush        = 1'b1;
        drive_check();
        tick();
        idle();
        drive_check();
        chk("flush count", count, 0);
        chk("flush empty", empty, 1);
        chk("flush alloc_idx", alloc_idx, 0);
        chk("flush retire_idx", retire_idx, 0);
        chk("flush retire_valid", retire_valid, 0);
        e = port_entry(1);
        chk("flush idx2 valid", e.valid, 0);
        chk("flush idx2 spec_valid", e.spec_valid, 0);

        alloc_valid  = 1'b1;
        alloc_rd_reg = 5'd4;
        drive_check();
        tick();
        idle();
        upd_valid = 1'b1;
        upd_idx   = 5'd0;
        upd_data  = 32'h1;
        drive_check();
        tick();
        upd_data = 32'h2;
        drive_check();
        tick();
        idle();
        drive_check();
        e = port_entry(0);
        chk("dbl upd data", e.spec_data, 32'h1);
        retire_ready = 1'b1;
        drive_check();
        tick();
        idle();
        upd_valid = 1'b1;
        upd_idx   = 5'd0;
        upd_data  = 32'h5;
        drive_check();
        e = port_entry(0);
        chk("freed upd bypass", e.spec_valid, 0);
        tick();
        idle();
        drive_check();
        e = port_entry(0);
        chk("freed upd valid", e.valid, 0);
        chk("freed upd spec_valid", e.spec_valid, 0);

        flush = 1'b1;
        tick();
        idle();
        for (int i = 0; i < DEPTH - 1; i++) begin
            alloc_valid  = 1'b1;
            alloc_rd_reg = 5'(i);
            tick();
        end
        idle();
        upd_valid = 1'b1;
        upd_idx   = 5'd0;
        upd_data  = 32'h77;
        drive_check();
        tick();
        idle();
        alloc_valid  = 1'b1;
        retire_ready = 1'b1;
        drive_check();
        chk("wrap alloc_idx", alloc_idx, 31);
        chk("wrap count before", count, 31);
        tick();
        idle();
        drive_check();
        chk("wrap count after", count, 31);
        chk("wrap tail", alloc_idx, 0);

        for (int c = 0; c < 3000; c++) begin
            reset        = ($urandom % 300) == 0;
            flush        = ($urandom % 60) == 0;
            alloc_valid  = ($urandom % 3) != 0;
            alloc_rd_reg = 5'($urandom);
            alloc_pc     = $urandom;
            alloc_type   = 2'($urandom);
            upd_valid    = ($urandom % 2) == 0;
            if (($urandom % 4) != 0 && m_count > 0)
                upd_idx = 5'((m_head + int'($urandom % m_count)) % DEPTH);
            else
                upd_idx = 5'($urandom);
            upd_data     = $urandom;
            retire_ready = ($urandom % 3) != 0;
            rd_addr      = 10'($urandom);
            if (!reset) drive_check();
            tick();
        end
        idle();
        drive_check();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
